// File: rtl/trading_pkg.sv
// Shared trading-path definitions: ASCII codes,
// parser state/target encodings and byte helpers.
package trading_pkg;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_T    = 8'h54;
  localparam logic [7:0] ASCII_P_LC = 8'h70;
  localparam logic [7:0] ASCII_T_LC = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGITS  = 2'd1,
    ST_DISCARD = 2'd2
  } parse_state_e;

  typedef enum logic {
    TGT_PRICE  = 1'b0,
    TGT_THRESH = 1'b1
  } target_e;

  function automatic logic is_digit(
    input logic [7:0] b
  );
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_price_parser.sv
// Line parser for P<digits>/T<digits> commands
// arriving from the UART receiver.
module uart_price_parser
  import trading_pkg::*;
#(
  parameter logic [15:0] DEFAULT_THRESHOLD = 16'd1000,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] price,
  output logic [15:0] threshold,
  output logic        new_price,
  output logic        new_threshold,
  output logic        parse_err
);

  localparam int NW = $clog2(MAX_DIGITS + 1);
  localparam logic [NW-1:0] NDIG_MAX =
    NW'(MAX_DIGITS);

  parse_state_e st_q, st_d;
  target_e      tgt_q, tgt_d;
  logic [15:0]  acc_q, acc_d;
  logic [NW-1:0] ndig_q, ndig_d;

  logic [15:0] price_d, thr_d;
  logic        np_d, nt_d, pe_d;

  logic        is_lf, is_cr;
  logic        is_p, is_t, is_dig;
  logic        dig_full, ovf;
  logic        dig_ok, dig_bad;
  logic [19:0] prod;

  assign is_lf  = rx_data == ASCII_LF;
  assign is_cr  = rx_data == ASCII_CR;
  assign is_p   = (rx_data == ASCII_P) ||
                  (rx_data == ASCII_P_LC);
  assign is_t   = (rx_data == ASCII_T) ||
                  (rx_data == ASCII_T_LC);
  assign is_dig = is_digit(rx_data);

  // Wide product so overflow is seen before truncation.
  assign prod = 20'(acc_q) * 20'd10
              + {16'b0, rx_data[3:0]};

  assign dig_full = ndig_q == NDIG_MAX;
  assign ovf      = prod > 20'h0FFFF;
  assign dig_ok   = is_dig && !dig_full && !ovf;
  assign dig_bad  = is_dig && (dig_full || ovf);

  // Next-state, accumulator and output update rules.
  always_comb begin
    st_d    = st_q;
    tgt_d   = tgt_q;
    acc_d   = acc_q;
    ndig_d  = ndig_q;
    price_d = price;
    thr_d   = threshold;
    np_d    = 1'b0;
    nt_d    = 1'b0;
    pe_d    = 1'b0;
    if (rx_valid && !is_cr) begin
      unique case (st_q)
        ST_IDLE: begin
          unique case (1'b1)
            is_p: begin
              st_d   = ST_DIGITS;
              tgt_d  = TGT_PRICE;
              acc_d  = '0;
              ndig_d = '0;
            end
            is_t: begin
              st_d   = ST_DIGITS;
              tgt_d  = TGT_THRESH;
              acc_d  = '0;
              ndig_d = '0;
            end
            is_lf: begin
              st_d = ST_IDLE;
            end
            default: begin
              st_d = ST_DISCARD;
              pe_d = 1'b1;
            end
          endcase
        end
        ST_DIGITS: begin
          unique case (1'b1)
            dig_ok: begin
              acc_d  = prod[15:0];
              ndig_d = ndig_q + NW'(1);
            end
            dig_bad: begin
              st_d = ST_DISCARD;
              pe_d = 1'b1;
            end
            is_lf && (ndig_q != '0): begin
              st_d = ST_IDLE;
              if (tgt_q == TGT_PRICE) begin
                price_d = acc_q;
                np_d    = 1'b1;
              end else begin
                thr_d = acc_q;
                nt_d  = 1'b1;
              end
            end
            is_lf && (ndig_q == '0): begin
              st_d = ST_IDLE;
              pe_d = 1'b1;
            end
            default: begin
              st_d = ST_DISCARD;
              pe_d = 1'b1;
            end
          endcase
        end
        ST_DISCARD: begin
          if (is_lf) st_d = ST_IDLE;
        end
        default: begin
          st_d = ST_IDLE;
        end
      endcase
    end
  end

  // Register parser state and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      tgt_q         <= TGT_PRICE;
      acc_q         <= '0;
      ndig_q        <= '0;
      price         <= '0;
      threshold     <= DEFAULT_THRESHOLD;
      new_price     <= 1'b0;
      new_threshold <= 1'b0;
      parse_err     <= 1'b0;
    end else begin
      st_q          <= st_d;
      tgt_q         <= tgt_d;
      acc_q         <= acc_d;
      ndig_q        <= ndig_d;
      price         <= price_d;
      threshold     <= thr_d;
      new_price     <= np_d;
      new_threshold <= nt_d;
      parse_err     <= pe_d;
    end
  end

endmodule

// File: tb/tb_uart_price_parser.sv
// Bench for uart_price_parser: line-level model
// compared every cycle, plus directed literals.
module tb_uart_price_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] price;
  logic [15:0] threshold;
  logic        new_price;
  logic        new_threshold;
  logic        parse_err;

  int tests = 0;
  int fails = 0;

  int np_cnt = 0;
  int nt_cnt = 0;
  int pe_cnt = 0;

  uart_price_parser dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .price         (price),
    .threshold     (threshold),
    .new_price     (new_price),
    .new_threshold (new_threshold),
    .parse_err     (parse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the text of the current line and
  // asks whether it is still a legal command prefix.
  int   m_price;
  int   m_thr;
  bit   m_np, m_nt, m_pe;
  byte  line[$];
  bit   dead;

  function automatic bit is_cmd(input byte c);
    return c == "P" || c == "p" ||
           c == "T" || c == "t";
  endfunction

  function automatic int line_val(input byte q[$]);
    int v = 0;
    for (int i = 1; i < q.size(); i++)
      v = v * 10 + (q[i] - "0");
    return v;
  endfunction

  function automatic bit prefix_ok(input byte q[$]);
    if (q.size() == 0) return 1'b1;
    if (!is_cmd(q[0])) return 1'b0;
    if (q.size() - 1 > 5) return 1'b0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] < "0" || q[i] > "9") return 1'b0;
    return line_val(q) <= 65535;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_price = 0;
      m_thr   = 1000;
      m_np    = 0;
      m_nt    = 0;
      m_pe    = 0;
      line.delete();
      dead    = 0;
    end else begin
      m_np = 0;
      m_nt = 0;
      m_pe = 0;
      if (rx_valid && rx_data != 8'h0D) begin
        if (rx_data == 8'h0A) begin
          if (!dead && line.size() == 1) begin
            m_pe = 1;
          end else if (!dead && line.size() > 1) begin
            if (line[0] == "P" || line[0] == "p") begin
              m_price = line_val(line);
              m_np    = 1;
            end else begin
              m_thr = line_val(line);
              m_nt  = 1;
            end
          end
          line.delete();
          dead = 0;
        end else if (!dead) begin
          line.push_back(rx_data);
          if (!prefix_ok(line)) begin
            m_pe = 1;
            dead = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("price", int'(price), m_price);
    chk("threshold", int'(threshold), m_thr);
    chk("new_price", int'(new_price), int'(m_np));
    chk("new_threshold", int'(new_threshold),
        int'(m_nt));
    chk("parse_err", int'(parse_err), int'(m_pe));
    chk("one_hot_strobes",
        int'(new_price) + int'(new_threshold) +
        int'(parse_err) <= 1 ? 1 : 0, 1);
    if (new_price) np_cnt++;
    if (new_threshold) nt_cnt++;
    if (parse_err) pe_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input byte b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_str(input string s,
                          input int max_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (max_gap > 0 && i != s.len() - 1)
        idle($urandom_range(max_gap, 0));
    end
  endtask

  function automatic string rand_line();
    string s;
    int    k;
    int    n;
    string alpha;
    alpha = "PpTtX0123456789a\r ";
    k = $urandom_range(9, 0);
    if (k < 6) begin
      s = $sformatf("%s", alpha[$urandom_range(3, 0)]);
      n = $urandom_range(6, 0);
      for (int i = 0; i < n; i++)
        s = {s, $sformatf("%c",
             8'($urandom_range(57, 48)))};
    end else if (k < 8) begin
      s = $sformatf("%c%0d",
            k == 6 ? "P" : "t",
            $urandom_range(65535, 0));
    end else begin
      s = "";
      n = $urandom_range(5, 0);
      for (int i = 0; i < n; i++)
        s = {s, $sformatf("%s",
             alpha[$urandom_range(alpha.len() - 1, 0)])};
    end
    return {s, "\n"};
  endfunction

  int p0, t0, e0;

  task automatic reject(input string s,
                        input string nm);
    int pr;
    pr = int'(price);
    e0 = pe_cnt;
    p0 = np_cnt;
    send_str(s, 0);
    idle(2);
    chk({nm, "_err_once"}, pe_cnt - e0, 1);
    chk({nm, "_no_update"}, np_cnt - p0, 0);
    chk({nm, "_price_held"}, int'(price), pr);
    send_str("P7\n", 0);
    chk({nm, "_then_p7"}, int'(price), 7);
    idle(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    chk("rst_price", int'(price), 0);
    chk("rst_threshold", int'(threshold), 1000);
    chk("rst_strobes",
        int'({new_price, new_threshold, parse_err}), 0);
    #10;
    rst_n = 1'b1;
    idle(3);

    p0 = np_cnt;
    send_str("P1234\r\n", 0);
    chk("p1234_price", int'(price), 1234);
    chk("p1234_strobe", int'(new_price), 1);
    chk("p1234_thr", int'(threshold), 1000);
    idle(1);
    chk("p1234_strobe_drop", int'(new_price), 0);
    chk("p1234_one_pulse", np_cnt - p0, 1);

    t0 = nt_cnt;
    send_str("t00500\n", 0);
    chk("t500_thr", int'(threshold), 500);
    chk("t500_strobe", int'(new_threshold), 1);
    chk("t500_price", int'(price), 1234);
    send_str("P65535\n", 0);
    chk("p65535_price", int'(price), 65535);
    chk("p65535_strobe", int'(new_price), 1);
    idle(1);
    chk("t500_one_pulse", nt_cnt - t0, 1);

    e0 = pe_cnt;
    p0 = np_cnt;
    send_str("P65536", 0);
    chk("ovf_err_timing", int'(parse_err), 1);
    send_str("\n", 0);
    idle(2);
    chk("ovf_price_held", int'(price), 65535);
    chk("ovf_err_once", pe_cnt - e0, 1);
    chk("ovf_no_update", np_cnt - p0, 0);

    reject("P123456\n", "too_many");
    reject("P\n", "no_digits");
    reject("X12\n", "bad_cmd");
    reject("P1a2\n", "non_digit");

    send_str("P12", 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_price", int'(price), 0);
    chk("async_rst_thr", int'(threshold), 1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e0 = pe_cnt;
    p0 = np_cnt;
    send_str("3\n", 0);
    idle(2);
    chk("midrst_err_once", pe_cnt - e0, 1);
    chk("midrst_price", int'(price), 0);
    chk("midrst_no_update", np_cnt - p0, 0);

    for (int i = 0; i < 400; i++) begin
      send_str(rand_line(), i % 2 == 0 ? 0 : 2);
      if ($urandom_range(3, 0) == 0) idle(1);
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
